mfm_writer: RTL
===============

Name: mfm_writer

Overview:
- MFM encoder/transmitter; the write-side counterpart of the mfm sector decoder.
- Formats one floppy field per start request: gap, sync, 3x A1 address mark (missing clock), mark byte, payload, CRC16, trailing gap.
- Emits active-low flux pulses on the drive write-data line and controls write gate.
- Payload bytes arrive from the system side over a valid/ready byte stream.

Parameters:
- clkspd, 25000000, system clock frequency in Hz.
- datarate, 250000, MFM data rate in bit/s; cell period CELL_CLKS = clkspd/(2*datarate) = 50 clocks at defaults.
- PULSE_CLKS, 12, width in clocks of each write-data low pulse; must be < CELL_CLKS.
- GAP_BYTES, 12, count of 0x4E bytes in the leading gap.

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  synchronous active-high reset.
- i_Start  in  1  one-cycle request to write a field; ignored unless idle.
- i_Mark  in  8  mark byte (0xFE ID, 0xFB data), sampled on accepted i_Start.
- i_Length  in  11  payload byte count 0..1024, sampled on accepted i_Start.
- i_Data  in  8  payload byte.
- i_Valid  in  1  i_Data valid.
- o_Ready  out  1  writer can accept i_Data this cycle.
- o_WriteData  out  1  flux pulse output, active low, idle high.
- o_WriteGate  out  1  drive write gate, active low, idle high.
- o_Busy  out  1  field in progress.
- o_Done  out  1  one-cycle pulse when field complete.
- o_Underrun  out  1  sticky; payload byte missing when needed.

Behaviour:
- Reset (sync, active-high): every output at idle value: o_WriteData=1, o_WriteGate=1, o_Busy=0, o_Done=0, o_Ready=0, o_Underrun=0; FSM to IDLE, CRC=0xFFFF, prev-data-bit=0. Reset mid-field aborts immediately; no trailing bytes.
- FSM: IDLE -> GAP (GAP_BYTES x 0x4E) -> SYNC (12 x 0x00) -> AM (3 x A1 special) -> MARK (i_Mark) -> DATA (i_Length bytes; skipped if 0) -> CRCH -> CRCL -> TRAIL (1 x 0x4E) -> IDLE.
- Accepted i_Start in IDLE: next cycle o_Busy=1, o_WriteGate=0, first cell of GAP begins. i_Start while busy ignored.
- Cell timing: cell counter 0..CELL_CLKS-1; each byte = 16 cells, MSB first, clock cell then data cell. Cell value 1 drives o_WriteData=0 for cycles 0..PULSE_CLKS-1 of that cell.
- MFM rule: data cell = data bit; clock cell = 1 iff previous data bit and current data bit both 0. Prev-data-bit carries across bytes and state boundaries; starts 0 at field start.
- AM bytes: cell pattern forced to 0x4489 (clock between data bits 4 and 3 suppressed); prev-data-bit=1 after each.
- CRC16-CCITT, poly 0x1021, MSB first, init 0xFFFF at start of AM; covers 3x A1, mark, payload. CRCH = CRC[15:8], CRCL = CRC[7:0].
- Byte buffer, one deep: o_Ready=1 in MARK/DATA while buffer empty and payload bytes remain unaccepted; transfer on i_Valid&&o_Ready. Buffer loaded into shifter at last cycle of previous byte.
- Underrun: DATA byte needed with empty buffer -> write 0x00 (included in CRC), set o_Underrun, byte counted. Cleared only by reset or next accepted i_Start.
- End: after TRAIL's last cell, o_WriteGate=1, o_Busy=0, o_Done=1 for exactly one cycle, same cycle.
- i_Length > 1024 clamped to 1024.

Optional Feature:
- MFM_STATE_OUT_EN: defined -> adds output port o_State[3:0] carrying FSM encoding (IDLE=0, GAP=1, SYNC=2, AM=3, MARK=4, DATA=5, CRCH=6, CRCL=7, TRAIL=8) for PMOD debug. Undefined -> port absent; function otherwise identical.

Test Plan:
- Reset held 3 cycles mid-DATA -> next cycle all outputs idle (WriteData=1, WriteGate=1, Busy=0, Ready=0), o_Done never pulses.
- Start, Mark=0xFE, Length=4, bytes 00 00 01 02 -> decoded cell stream shows CRC bytes 0xCA 0x6F; o_Done exactly (12+12+3+1+4+2+1)*800 = 28000 cycles after start.
- Observe AM: three consecutive 16-cell groups equal 0x4489; low pulses 12 cycles wide at cell starts, spaced in multiples of 50 clocks.
- Data byte 0x00 after 0x00 -> cells 0xAAAA; 0xFF -> 0x5555; 0x00 after 0x01 -> clock bit 0 suppressed, 0x2AAA.
- Length=2, i_Valid held low -> o_Underrun=1, 0x00 bytes written, CRC matches A1A1A1 FB 00 00; i_Start during field ignored.
- Length=0, Mark=0xFB -> no o_Ready asserted; CRC follows mark directly; o_Done after 31*800 cycles.

Source files
------------

// File: rtl/mfm_writer.sv
// MFM field writer: gap, sync, A1 address marks, mark byte, payload, CRC16 and trailing gap as write-data flux pulses.
// Define MFM_STATE_OUT_EN to expose the FSM encoding on o_State for debug.
module mfm_writer #(
    parameter int clkspd     = 25000000,
    parameter int datarate   = 250000,
    parameter int PULSE_CLKS = 12,
    parameter int GAP_BYTES  = 12
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic [7:0]  i_Mark,
    input  logic [10:0] i_Length,
    input  logic [7:0]  i_Data,
    input  logic        i_Valid,
    output logic        o_Ready,
    output logic        o_WriteData,
    output logic        o_WriteGate,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Underrun
`ifdef MFM_STATE_OUT_EN
    ,
    output logic [3:0]  o_State
`endif
);

    localparam int CELL_CLKS = clkspd / (2 * datarate);
    localparam int CW        = (CELL_CLKS > 1) ? $clog2(CELL_CLKS) : 1;
    localparam logic [CW-1:0] CELL_LAST = CW'(CELL_CLKS - 1);
    localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CLKS);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        GAP   = 4'd1,
        SYNC  = 4'd2,
        AM    = 4'd3,
        MARK  = 4'd4,
        DATA  = 4'd5,
        CRCH  = 4'd6,
        CRCL  = 4'd7,
        TRAIL = 4'd8
    } state_t;

    state_t      state, state_n;
    logic [CW-1:0] cell_cnt;
    logic [3:0]  cell_idx;
    logic [10:0] byte_cnt, byte_cnt_n;
    logic [15:0] cells, cells_n;
    logic [15:0] crc, crc_n;
    logic        prev_bit, prev_n, prev_in;
    logic [7:0]  mark_reg;
    logic [10:0] len_reg;
    logic [10:0] acc_cnt;
    logic [7:0]  buf_data;
    logic        buf_full;
    logic        underrun;
    logic        done, done_n;
    logic        busy, byte_end, take;
    logic        load, load_am, fetch;
    logic [7:0]  load_byte;
    logic [7:0]  pay_byte;
    logic        pay_miss;

    function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Clock cell is written only between two zero data bits.
    function automatic logic [15:0] mfm_enc(input logic [7:0] b, input logic p_in);
        logic [15:0] r;
        logic        p;
        r = 16'h0000;
        p = p_in;
        for (int i = 7; i >= 0; i--) begin
            r[2*i+1] = ~p & ~b[i];
            r[2*i]   = b[i];
            p        = b[i];
        end
        return r;
    endfunction

    assign busy     = (state != IDLE);
    assign byte_end = busy && (cell_cnt == CELL_LAST) && (cell_idx == 4'd15);
    assign o_Ready  = ((state == MARK) || (state == DATA)) && !buf_full && (acc_cnt < len_reg);
    assign take     = i_Valid && o_Ready;
    assign prev_in  = (state == IDLE) ? 1'b0 : prev_bit;

    // A byte handed over in the very cycle it is needed is used directly.
    assign pay_byte = buf_full ? buf_data : (take ? i_Data : 8'h00);
    assign pay_miss = !buf_full && !take;

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        crc_n      = crc;
        load       = 1'b0;
        load_am    = 1'b0;
        load_byte  = 8'h00;
        fetch      = 1'b0;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (i_Start) begin
                    state_n    = GAP;
                    load       = 1'b1;
                    load_byte  = 8'h4E;
                    byte_cnt_n = 11'd0;
                end
            end
            GAP: begin
                if (byte_end) begin
                    load = 1'b1;
                    if (byte_cnt == 11'(GAP_BYTES - 1)) begin
                        state_n    = SYNC;
                        load_byte  = 8'h00;
                        byte_cnt_n = 11'd0;
                    end else begin
                        load_byte  = 8'h4E;
                        byte_cnt_n = byte_cnt + 11'd1;
                    end
                end
            end
            SYNC: begin
                if (byte_end) begin
                    load = 1'b1;
                    if (byte_cnt == 11'd11) begin
                        state_n    = AM;
                        load_am    = 1'b1;
                        crc_n      = crc_upd(16'hFFFF, 8'hA1);
                        byte_cnt_n = 11'd0;
                    end else begin
                        load_byte  = 8'h00;
                        byte_cnt_n = byte_cnt + 11'd1;
                    end
                end
            end
            AM: begin
                if (byte_end) begin
                    load = 1'b1;
                    if (byte_cnt == 11'd2) begin
                        state_n    = MARK;
                        load_byte  = mark_reg;
                        crc_n      = crc_upd(crc, mark_reg);
                        byte_cnt_n = 11'd0;
                    end else begin
                        load_am    = 1'b1;
                        crc_n      = crc_upd(crc, 8'hA1);
                        byte_cnt_n = byte_cnt + 11'd1;
                    end
                end
            end
            MARK: begin
                if (byte_end) begin
                    load       = 1'b1;
                    byte_cnt_n = 11'd0;
                    if (len_reg == 11'd0) begin
                        state_n   = CRCH;
                        load_byte = crc[15:8];
                    end else begin
                        state_n   = DATA;
                        fetch     = 1'b1;
                        load_byte = pay_byte;
                        crc_n     = crc_upd(crc, pay_byte);
                    end
                end
            end
            DATA: begin
                if (byte_end) begin
                    load = 1'b1;
                    if (byte_cnt == len_reg - 11'd1) begin
                        state_n    = CRCH;
                        load_byte  = crc[15:8];
                        byte_cnt_n = 11'd0;
                    end else begin
                        fetch      = 1'b1;
                        load_byte  = pay_byte;
                        crc_n      = crc_upd(crc, pay_byte);
                        byte_cnt_n = byte_cnt + 11'd1;
                    end
                end
            end
            CRCH: begin
                if (byte_end) begin
                    state_n   = CRCL;
                    load      = 1'b1;
                    load_byte = crc[7:0];
                end
            end
            CRCL: begin
                if (byte_end) begin
                    state_n   = TRAIL;
                    load      = 1'b1;
                    load_byte = 8'h4E;
                end
            end
            TRAIL: begin
                if (byte_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Address marks use the A1 pattern with one clock pulse removed.
    assign cells_n = load_am ? 16'h4489 : mfm_enc(load_byte, prev_in);
    assign prev_n  = load_am ? 1'b1 : load_byte[0];

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state    <= IDLE;
            cell_cnt <= '0;
            cell_idx <= 4'd0;
            byte_cnt <= 11'd0;
            cells    <= 16'h0000;
            crc      <= 16'hFFFF;
            prev_bit <= 1'b0;
            mark_reg <= 8'h00;
            len_reg  <= 11'd0;
            acc_cnt  <= 11'd0;
            buf_data <= 8'h00;
            buf_full <= 1'b0;
            underrun <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            done     <= done_n;
            byte_cnt <= byte_cnt_n;
            crc      <= crc_n;
            if (load) begin
                cells    <= cells_n;
                prev_bit <= prev_n;
            end
            if (state == IDLE) begin
                cell_cnt <= '0;
                cell_idx <= 4'd0;
                if (i_Start) begin
                    mark_reg <= i_Mark;
                    len_reg  <= (i_Length > 11'd1024) ? 11'd1024 : i_Length;
                    acc_cnt  <= 11'd0;
                    buf_full <= 1'b0;
                    underrun <= 1'b0;
                end
            end else begin
                if (cell_cnt == CELL_LAST) begin
                    cell_cnt <= '0;
                    cell_idx <= cell_idx + 4'd1;
                end else begin
                    cell_cnt <= cell_cnt + CW'(1);
                end
            end
            if (fetch) begin
                buf_full <= 1'b0;
                if (pay_miss) underrun <= 1'b1;
            end else if (take) begin
                buf_full <= 1'b1;
                buf_data <= i_Data;
            end
            if (take || (fetch && pay_miss)) acc_cnt <= acc_cnt + 11'd1;
        end
    end

    assign o_WriteData = ~(busy && cells[4'd15 - cell_idx] && (cell_cnt < PULSE_END));
    assign o_WriteGate = ~busy;
    assign o_Busy      = busy;
    assign o_Done      = done;
    assign o_Underrun  = underrun;
`ifdef MFM_STATE_OUT_EN
    assign o_State     = state;
`endif

endmodule
